// File: rtl/memory_arbiter.sv
// Two-master arbiter: dcache and icache share one single-word RAM port.
// Data has priority; a starvation counter forces an instruction grant.
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       proto_err_q;
  logic       dreq, acc;

  assign dreq      = dREN | dWEN;
  assign acc       = (ramstate == RAM_ACCESS);
  assign iload     = ramload;
  assign dload     = ramload;
  assign proto_err = proto_err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if (dREN && dWEN) proto_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'd0;
    ramstore     = 32'd0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    case (state_q)
      IDLE: begin
        // >= also catches a count that overshot when iREN rose mid-grant
        if (dreq && !(iREN && starve_cnt_q >= STARVE_LIM)) state_d = DATA;
        else if (iREN)                                       state_d = INST;
      end
      DATA: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~(dreq & acc);
        if (!dreq) begin
          state_d = IDLE;
        end else if (acc) begin
          state_d = IDLE;
          if (!iREN)                     starve_cnt_d = 4'd0;
          else if (starve_cnt_q != 4'hF) starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      INST: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~(iREN & acc);
        if (!iREN) begin
          state_d = IDLE;
        end else if (acc) begin
          state_d      = IDLE;
          starve_cnt_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a grant-owner model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_memory_arbiter;
  localparam int STARVE = 4;
  localparam int LAT    = 2;

  logic        CLK = 0, nRST = 0;
  logic        iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, proto_err;
  logic [1:0]  ramstate;

  int checks = 0, errors = 0;

  memory_arbiter #(.STARVE_MAX(STARVE)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  // RAM emulator: BUSY for LAT cycles of an enabled access, then ACCESS.
  int ram_mode = 0; // 0 normal, 1 force ERROR, 2 force BUSY
  int lat_cnt  = 0;
  always @(posedge CLK) lat_cnt <= (ramREN | ramWEN) ? lat_cnt + 1 : 0;
  always_comb begin
    ramstate = 2'd0;
    if (ram_mode == 1)             ramstate = 2'd3;
    else if (ram_mode == 2)        ramstate = 2'd1;
    else if (ramREN | ramWEN)      ramstate = (lat_cnt >= LAT) ? 2'd2 : 2'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: who owns the RAM port (0 none, 1 dcache, 2 icache) and the data-streak count.
  int m_own = 0, m_cnt = 0;
  bit m_perr = 0;
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_own <= 0; m_cnt <= 0; m_perr <= 0;
    end else begin
      if (dREN && dWEN) m_perr <= 1;
      if (m_own == 0) begin
        if ((dREN || dWEN) && !(iREN && m_cnt >= STARVE)) m_own <= 1;
        else if (iREN) m_own <= 2;
      end else if (m_own == 1) begin
        if (!(dREN || dWEN)) m_own <= 0;
        else if (ramstate == 2'd2) begin
          m_own <= 0;
          m_cnt <= iREN ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
        end
      end else begin
        if (!iREN) m_own <= 0;
        else if (ramstate == 2'd2) begin m_own <= 0; m_cnt <= 0; end
      end
    end
  end

  always @(negedge CLK) begin : cmp
    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_st;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_addr = 0; e_st = 0;
    if (m_own == 1) begin
      e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_st = dstore;
      e_dw  = !((dREN || dWEN) && ramstate == 2'd2);
    end else if (m_own == 2) begin
      e_ren = 1; e_addr = iaddr;
      e_iw  = !(iREN && ramstate == 2'd2);
    end
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_st);
    chk("iwait", 32'(iwait), 32'(e_iw));
    chk("dwait", 32'(dwait), 32'(e_dw));
    chk("iload", iload, ramload);
    chk("dload", dload, ramload);
    chk("proto_err", 32'(proto_err), 32'(m_perr));
  end

  task automatic step();
    @(posedge CLK); #2;
  endtask

  initial begin
    int    nren, nw, nd;
    logic [31:0] ld;
    string ord;
    bit    seen;

    // reset values
    #1;
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    step(); step(); nRST = 1;

    // 1: lone instruction fetch, latency 2
    step(); iREN = 1; iaddr = 32'h40; ramload = 32'hDEADBEEF;
    nren = 0; nw = 0; ld = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (ramREN) nren++;
      if (!iwait) begin
        nw++; ld = iload;
        @(posedge CLK); #2; iREN = 0;
      end
    end
    chk("t1_ramREN_cycles", nren, 3);
    chk("t1_iwait_low_cycles", nw, 1);
    chk("t1_iload", ld, 32'hDEADBEEF);

    // 2: simultaneous requests, data first, then one bubble, then instruction
    step(); dREN = 1; daddr = 32'h1000; iREN = 1; iaddr = 32'h2000; ramload = 32'h12345678;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (!dwait) begin
        seen = 1;
        chk("t2_first_addr", ramaddr, 32'h1000);
        chk("t2_iwait_during_d", 32'(iwait), 1);
      end
    end
    chk("t2_d_done", 32'(seen), 1);
    step(); dREN = 0;
    @(negedge CLK);
    chk("t2_bubble_ramREN", 32'(ramREN), 0);
    @(negedge CLK);
    chk("t2_i_grant_ramREN", 32'(ramREN), 1);
    chk("t2_i_grant_addr", ramaddr, 32'h2000);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (!iwait) seen = 1;
    end
    chk("t2_i_done", 32'(seen), 1);
    step(); iREN = 0;

    // 3: write stream vs pending fetch: starvation guard
    step(); dWEN = 1; daddr = 32'h100; dstore = 32'hA5; iREN = 1; iaddr = 32'h200;
    ramload = 32'h11112222;
    ord = "";
    for (int c = 0; c < 300 && ord.len() < 10; c++) begin
      @(negedge CLK);
      if (!dwait) ord = {ord, "D"};
      if (!iwait) ord = {ord, "I"};
    end
    checks++;
    if (ord != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL t3_order: got %s expected DDDDIDDDDI", ord);
    end
    step(); dWEN = 0; iREN = 0;

    // 4: ERROR for 3 cycles, then ACCESS
    step(); dWEN = 1; daddr = 32'h3100; dstore = 32'h7; ram_mode = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      if (ramWEN) seen = 1;
    end
    chk("t4_granted", 32'(seen), 1);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge CLK);
      chk("t4_err_ramWEN", 32'(ramWEN), 1);
      chk("t4_err_ramstore", ramstore, 32'h7);
      if (!dwait) nd++;
    end
    step(); ram_mode = 0;
    @(negedge CLK);
    chk("t4_acc_ramWEN", 32'(ramWEN), 1);
    chk("t4_acc_addr", ramaddr, 32'h3100);
    if (!dwait) nd++;
    step(); dWEN = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (!dwait) nd++;
    end
    chk("t4_dwait_low_cycles", nd, 1);

    // request dropped while stalled: back to IDLE, no completion
    step(); dREN = 1; daddr = 32'h44; ram_mode = 2;
    @(negedge CLK); @(negedge CLK);
    chk("drop_granted", 32'(ramREN), 1);
    step(); dREN = 0; ram_mode = 0;
    @(negedge CLK);
    chk("drop_dwait", 32'(dwait), 1);
    @(negedge CLK);
    chk("drop_idle_ramREN", 32'(ramREN), 0);

    // 5: dREN and dWEN together
    step(); dREN = 1; dWEN = 1; daddr = 32'h500; dstore = 32'h99;
    @(negedge CLK); @(negedge CLK);
    chk("t5_ramWEN", 32'(ramWEN), 1);
    chk("t5_ramREN", 32'(ramREN), 0);
    chk("t5_proto_err", 32'(proto_err), 1);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      if (!dwait) seen = 1;
    end
    chk("t5_done", 32'(seen), 1);
    step(); dREN = 0; dWEN = 0;
    repeat (3) @(negedge CLK);
    chk("t5_proto_err_sticky", 32'(proto_err), 1);

    // 6: reset during a stalled fetch
    step(); iREN = 1; iaddr = 32'h80; ram_mode = 2;
    @(negedge CLK); @(negedge CLK);
    chk("t6_inst_ramREN", 32'(ramREN), 1);
    #2 nRST = 0;
    #1;
    chk("t6_rst_ramREN", 32'(ramREN), 0);
    chk("t6_rst_iwait", 32'(iwait), 1);
    chk("t6_rst_proto_err", 32'(proto_err), 0);
    iREN = 0; ram_mode = 0;
    step(); step(); nRST = 1;
    @(negedge CLK);
    chk("t6_idle_ramREN", 32'(ramREN), 0);
    chk("t6_idle_dwait", 32'(dwait), 1);

    // fresh fetch after reset
    step(); iREN = 1; iaddr = 32'h84; ramload = 32'hCAFEF00D;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      if (!iwait) begin seen = 1; chk("t6_post_iload", iload, 32'hCAFEF00D); end
    end
    chk("t6_post_done", 32'(seen), 1);
    step(); iREN = 0;
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
